door_input_conditioner: RTL and testbench
=========================================

DOOR_INPUT_CONDITIONER -- requirements
Module: door_input_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive sample ticks a channel must disagree with its output before the output flips (range 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1000: sample ticks the presence output stays high after the debounced sensor falls (range 1..65535).
REQ-003 SHALL have port clk, in, 1: single system clock.
REQ-004 SHALL have port rst_n, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tick_en, in, 1: sample strobe; tie high to sample every clk.
REQ-006 SHALL have ports sen_raw, se_raw, la_raw, lc_raw, in, 1 each: raw presence sensor, emergency stop, open limit, close limit.
REQ-007 SHALL have ports sen, se, la, lc, out, 1 each: conditioned signals feeding the door FSM inputs Sen, SE, LA, LC.
REQ-008 SHALL have port sen_rise, out, 1: one-clk pulse on each 0->1 of sen.
REQ-009 SHALL have port limit_fault, out, 1: both limit switches asserted.

Function
REQ-010 SHALL pass each raw input through a 2-flop synchronizer before any other logic.
REQ-011 Debounce, sen/la/lc: SHALL use a per-channel counter that increments on each tick_en while the synced value differs from the debounced value and clears whenever they match; at count DEB_CYCLES the debounced value SHALL take the synced value and the counter SHALL clear.
REQ-012 Debounce, se: assertion SHALL bypass the counter (debounced se=1 on the first tick_en after the synced value is 1); deassertion SHALL be debounced per REQ-011.
REQ-013 Latency, tick_en=1: a stable raw change on sen/la/lc SHALL reach the debounced value 2+DEB_CYCLES clks later; se assertion SHALL reach it after 3 clks.
REQ-014 Counters SHALL hold their value when tick_en=0 and SHALL saturate, never wrap.
REQ-015 Presence FSM states: IDLE (sen=0), ACTIVE (sen=1), HOLD (sen=1, hold counter running).
REQ-016 IDLE->ACTIVE when debounced sen=1.
REQ-017 ACTIVE->HOLD when debounced sen=0; the hold counter SHALL load 0.
REQ-018 HOLD SHALL increment the hold counter on each tick_en and go HOLD->IDLE when it reaches HOLD_CYCLES.
REQ-019 HOLD->ACTIVE when debounced sen=1; this SHALL take priority over expiry in the same cycle, and the hold counter SHALL clear.
REQ-020 sen_rise SHALL pulse for one clk only on IDLE->ACTIVE, never on HOLD->ACTIVE.
REQ-021 limit_fault SHALL set when debounced la=1 and debounced lc=1 in the same cycle; it SHALL stay set until both are 0 simultaneously.
REQ-022 While limit_fault=1, la and lc outputs SHALL be forced to 0.
REQ-023 se output SHALL equal debounced se OR limit_fault.
REQ-024 All outputs SHALL be registered, with no combinational path from raw inputs.

Reset
REQ-025 rst_n=0 SHALL immediately clear synchronizers, debounced values, all counters, and the outputs sen, se, la, lc, sen_rise and limit_fault, and SHALL put the FSM in IDLE.
REQ-026 After rst_n deassertion, an input already high SHALL follow the REQ-013 latency, with no sen_rise before sen rises.
REQ-027 Reset during HOLD SHALL discard the remaining hold time.

Structure
REQ-028 Package door_pkg SHALL hold the presence-state enum (IDLE, ACTIVE, HOLD) and the default DEB_CYCLES and HOLD_CYCLES constants.
REQ-029 Synchronizer plus debounce SHALL be one sub-module, debounce_cell, with parameter FAST_ASSERT, instantiated four times; the se instance SHALL set FAST_ASSERT=1.

Verification (DEB_CYCLES=4, HOLD_CYCLES=10, tick_en=1)
REQ-030 sen_raw 0->1 held -> sen=1 6 clks later; sen_rise high for exactly 1 clk.
REQ-031 sen_raw glitches of 3 clks high / 3 clks low, repeated -> sen stays 0; counter never reaches 4.
REQ-032 sen_raw drops after sen=1 -> sen falls 2+4+10 clks later; sen_raw re-raised at clk 9 of HOLD -> sen never drops and no sen_rise.
REQ-033 la_raw=1 then lc_raw=1 -> limit_fault=1, la=lc=0, se=1; lc_raw released -> fault persists; la_raw released -> fault clears after the debounced la falls.
REQ-034 se_raw 1-clk pulse -> se=1 after 3 clks, then se=0 only after 4 ticks of stable low.
REQ-035 rst_n pulsed low during HOLD -> all outputs 0 at once; sen_raw still high -> sen=1 6 clks after release.

Source files
------------

// File: rtl/door_pkg.sv
// Shared types and default timing constants for the door input conditioner.
package door_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } presence_state_e;

  localparam int unsigned DEB_CYCLES_DEF  = 32'd16;
  localparam int unsigned HOLD_CYCLES_DEF = 32'd1000;

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchronizer followed by a saturating tick-based debouncer.
// deb_next is the debounced value the channel will hold after the coming clock edge.
module debounce_cell
  import door_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter bit          FAST_ASSERT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic raw,
  output logic deb_next
);

  localparam logic [8:0] DEB_LIM = 9'(DEB_CYCLES);

  logic       meta_r;
  logic       sync_r;
  logic       deb_r;
  logic       deb_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;

  // Synchronizer chain, shifts every clock regardless of tick_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  // Debounce decision; fast-assert channels take a synced 1 without waiting
  always_comb begin
    deb_nxt_s = deb_r;
    cnt_nxt_s = cnt_r;
    if (tick_en) begin
      if (sync_r == deb_r) begin
        cnt_nxt_s = 8'd0;
      end else if (FAST_ASSERT && sync_r) begin
        deb_nxt_s = 1'b1;
        cnt_nxt_s = 8'd0;
      end else if (({1'b0, cnt_r} + 9'd1) >= DEB_LIM) begin
        deb_nxt_s = sync_r;
        cnt_nxt_s = 8'd0;
      end else if (cnt_r != 8'hFF) begin
        cnt_nxt_s = cnt_r + 8'd1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      deb_nxt_s = deb_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Debounce state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 1'b0;
      cnt_r <= 8'd0;
    end else begin
      deb_r <= deb_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign deb_next = deb_nxt_s;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions raw door sensors for the door FSM: debounce, presence hold-off,
// rising-edge pulse on presence, and a latched fault when both limits read active.
module door_input_conditioner
  import door_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic sen_raw,
  input  logic se_raw,
  input  logic la_raw,
  input  logic lc_raw,
  output logic sen,
  output logic se,
  output logic la,
  output logic lc,
  output logic sen_rise,
  output logic limit_fault
);

  localparam logic [16:0] HOLD_LIM = 17'(HOLD_CYCLES);

  logic            sen_deb_s;
  logic            se_deb_s;
  logic            la_deb_s;
  logic            lc_deb_s;
  presence_state_e state_r;
  presence_state_e state_nxt_s;
  logic [15:0]     hold_cnt_r;
  logic [15:0]     hold_cnt_nxt_s;
  logic            fault_nxt_s;
  logic            sen_r;
  logic            se_r;
  logic            la_r;
  logic            lc_r;
  logic            sen_rise_r;
  logic            fault_r;

  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_ASSERT(1'b0)) u_sen (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .raw(sen_raw), .deb_next(sen_deb_s)
  );
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_ASSERT(1'b1)) u_se (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .raw(se_raw), .deb_next(se_deb_s)
  );
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_ASSERT(1'b0)) u_la (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .raw(la_raw), .deb_next(la_deb_s)
  );
  debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_ASSERT(1'b0)) u_lc (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .raw(lc_raw), .deb_next(lc_deb_s)
  );

  // Presence FSM; a returning sensor wins over hold expiry in the same cycle
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (sen_deb_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (!sen_deb_s) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = 16'd0;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      HOLD: begin
        if (sen_deb_s) begin
          state_nxt_s    = ACTIVE;
          hold_cnt_nxt_s = 16'd0;
        end else if (tick_en) begin
          if (({1'b0, hold_cnt_r} + 17'd1) >= HOLD_LIM) begin
            state_nxt_s    = IDLE;
            hold_cnt_nxt_s = 16'd0;
          end else begin
            hold_cnt_nxt_s = hold_cnt_r + 16'd1;
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        hold_cnt_nxt_s = 16'd0;
      end
    endcase
  end

  // Limit fault latches on both limits and releases only when both read clear
  always_comb begin
    fault_nxt_s = fault_r;
    if (fault_r) begin
      fault_nxt_s = la_deb_s | lc_deb_s;
    end else begin
      fault_nxt_s = la_deb_s & lc_deb_s;
    end
  end

  // FSM and output registers, all fed from post-edge values so outputs align with debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= 16'd0;
      sen_r      <= 1'b0;
      se_r       <= 1'b0;
      la_r       <= 1'b0;
      lc_r       <= 1'b0;
      sen_rise_r <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      sen_r      <= (state_nxt_s != IDLE);
      sen_rise_r <= (state_r == IDLE) && (state_nxt_s == ACTIVE);
      fault_r    <= fault_nxt_s;
      la_r       <= la_deb_s & ~fault_nxt_s;
      lc_r       <= lc_deb_s & ~fault_nxt_s;
      se_r       <= se_deb_s | fault_nxt_s;
    end
  end

  assign sen         = sen_r;
  assign se          = se_r;
  assign la          = la_r;
  assign lc          = lc_r;
  assign sen_rise    = sen_rise_r;
  assign limit_fault = fault_r;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Randomized and directed bench for door_input_conditioner against a timestamp-based reference model.
module tb_door_input_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic clk;
  logic rst_n;
  logic tick_en;
  logic sen_raw;
  logic se_raw;
  logic la_raw;
  logic lc_raw;
  logic sen;
  logic se;
  logic la;
  logic lc;
  logic sen_rise;
  logic limit_fault;

  int n_checks;
  int n_pass;

  // reference model: channel order sen, se, la, lc
  bit m_r1 [4];
  bit m_r2 [4];
  bit m_deb [4];
  int m_last [4];
  int m_tick;
  int m_rem;
  bit e_sen, e_se, e_la, e_lc, e_rise, e_fault;

  door_input_conditioner #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .sen_raw(sen_raw), .se_raw(se_raw), .la_raw(la_raw), .lc_raw(lc_raw),
    .sen(sen), .se(se), .la(la), .lc(lc),
    .sen_rise(sen_rise), .limit_fault(limit_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_r1[c] = 1'b0; m_r2[c] = 1'b0; m_deb[c] = 1'b0; m_last[c] = 0;
    end
    m_tick = 0; m_rem = 0;
    e_sen = 1'b0; e_se = 1'b0; e_la = 1'b0; e_lc = 1'b0; e_rise = 1'b0; e_fault = 1'b0;
  endtask

  function automatic bit raw_of(input int c);
    case (c)
      0: return sen_raw;
      1: return se_raw;
      2: return la_raw;
      default: return lc_raw;
    endcase
  endfunction

  // one clock edge of the model: a channel flips once DEB consecutive ticked samples disagree
  task automatic model_step();
    bit synced;
    bit prev_sen_deb;
    bit prev_sen;
    prev_sen_deb = m_deb[0];
    prev_sen = e_sen;
    if (tick_en) m_tick++;
    for (int c = 0; c < 4; c++) begin
      synced = m_r2[c];
      m_r2[c] = m_r1[c];
      m_r1[c] = raw_of(c);
      if (tick_en) begin
        if (synced == m_deb[c]) m_last[c] = m_tick;
        else if (c == 1 && synced) begin m_deb[c] = 1'b1; m_last[c] = m_tick; end
        else if (m_tick - m_last[c] >= DEB) begin m_deb[c] = synced; m_last[c] = m_tick; end
      end
    end
    if (m_deb[0]) m_rem = 0;
    else if (prev_sen_deb) m_rem = HOLD;
    else if (tick_en && m_rem > 0) m_rem--;
    e_sen = m_deb[0] || (m_rem > 0);
    e_rise = e_sen && !prev_sen;
    e_fault = e_fault ? (m_deb[2] | m_deb[3]) : (m_deb[2] & m_deb[3]);
    e_la = m_deb[2] & ~e_fault;
    e_lc = m_deb[3] & ~e_fault;
    e_se = m_deb[1] | e_fault;
  endtask

  task automatic compare_all();
    check_eq("sen", sen, e_sen);
    check_eq("se", se, e_se);
    check_eq("la", la, e_la);
    check_eq("lc", lc, e_lc);
    check_eq("sen_rise", sen_rise, e_rise);
    check_eq("limit_fault", limit_fault, e_fault);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0: return sen;
      1: return se;
      2: return la;
      3: return lc;
      4: return sen_rise;
      default: return limit_fault;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic val, input int budget, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      cycle();
      n++;
      if (get_out(sel) == val) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  // asynchronous reset mid-cycle: outputs must clear before any clock edge
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_sen"}, sen, 1'b0);
    check_eq({tag, "_se"}, se, 1'b0);
    check_eq({tag, "_la"}, la, 1'b0);
    check_eq({tag, "_lc"}, lc, 1'b0);
    check_eq({tag, "_rise"}, sen_rise, 1'b0);
    check_eq({tag, "_fault"}, limit_fault, 1'b0);
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int cnt;
    int lo;
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    tick_en = 1'b1;
    sen_raw = 1'b0; se_raw = 1'b0; la_raw = 1'b0; lc_raw = 1'b0;
    model_reset();
    #1;
    check_eq("rst_sen", sen, 1'b0);
    check_eq("rst_se", se, 1'b0);
    check_eq("rst_fault", limit_fault, 1'b0);
    run(2);
    rst_n = 1'b1;
    run(4);

    // 3-high/3-low glitches never get through
    cnt = 0;
    repeat (5) begin
      sen_raw = 1'b1;
      repeat (3) begin cycle(); if (sen) cnt++; end
      sen_raw = 1'b0;
      repeat (3) begin cycle(); if (sen) cnt++; end
    end
    check_eq("glitch_sen", cnt, 0);
    run(6);

    // presence rise latency and single-cycle pulse
    sen_raw = 1'b1;
    count_until(0, 1'b1, 20, n);
    check_eq("sen_rise_latency", n, 2 + DEB);
    check_eq("rise_with_sen", sen_rise, 1'b1);
    cnt = 0;
    repeat (5) begin cycle(); if (sen_rise) cnt++; end
    check_eq("rise_extra", cnt, 0);

    // fall goes through debounce then full hold time
    sen_raw = 1'b0;
    count_until(0, 1'b0, 40, n);
    check_eq("sen_fall_latency", n, 2 + DEB + HOLD);

    // sensor returns late in HOLD, including on the expiry edge itself
    for (int off = 9; off <= 10; off++) begin
      sen_raw = 1'b1;
      run(12);
      sen_raw = 1'b0;
      lo = 0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
        if (i == off) sen_raw = 1'b1;
        cycle();
        if (!sen) lo++;
        if (sen_rise) cnt++;
      end
      check_eq("hold_reraise_drop", lo, 0);
      check_eq("hold_reraise_rise", cnt, 0);
    end
    sen_raw = 1'b0;
    run(25);

    // limit fault sequence
    la_raw = 1'b1;
    run(10);
    lc_raw = 1'b1;
    run(10);
    check_eq("fault_set", limit_fault, 1'b1);
    check_eq("fault_la", la, 1'b0);
    check_eq("fault_lc", lc, 1'b0);
    check_eq("fault_se", se, 1'b1);
    lc_raw = 1'b0;
    run(10);
    check_eq("fault_persist", limit_fault, 1'b1);
    la_raw = 1'b0;
    count_until(5, 1'b0, 20, n);
    check_eq("fault_clear_latency", n, 2 + DEB);
    check_eq("fault_clear_se", se, 1'b0);
    run(4);

    // single-clock emergency stop pulse
    se_raw = 1'b1;
    cycle();
    se_raw = 1'b0;
    count_until(1, 1'b1, 10, n);
    check_eq("se_assert_latency", n + 1, 3);
    cnt = 1;
    repeat (10) begin cycle(); if (se) cnt++; end
    check_eq("se_high_width", cnt, DEB);

    // reset while holding presence
    sen_raw = 1'b1;
    run(10);
    sen_raw = 1'b0;
    run(10);
    check_eq("hold_before_reset", sen, 1'b1);
    sen_raw = 1'b1;
    pulse_reset("rst_hold");
    count_until(0, 1'b1, 20, n);
    check_eq("sen_after_reset_latency", n, 2 + DEB);
    check_eq("rise_after_reset", sen_rise, 1'b1);

    // random traffic with sparse ticks and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) sen_raw = ~sen_raw;
      if ($urandom_range(0, 15) == 0) se_raw = ~se_raw;
      if ($urandom_range(0, 13) == 0) la_raw = ~la_raw;
      if ($urandom_range(0, 13) == 0) lc_raw = ~lc_raw;
      tick_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 599) == 0) pulse_reset("rst_rand");
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
